// File: rtl/sha2_pkg.sv
// sha2_pkg: shared SHA-2 constants, state encoding and word helpers for the scheduler and compression core.
package sha2_pkg;
    localparam logic SHA_256 = 1'b0;
    localparam logic SHA_512 = 1'b1;
    localparam int ROUNDS_256 = 64;
    localparam int ROUNDS_512 = 80;
    localparam int WORD_256 = 32;
    localparam int WORD_512 = 64;
    localparam int BUF_DEPTH = 16;
    localparam logic [6:0] LAST_256 = 7'(ROUNDS_256 - 1);
    localparam logic [6:0] LAST_512 = 7'(ROUNDS_512 - 1);

    typedef enum logic [1:0] {IDLE, LOAD_HI, ROUND} state_e;

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (WORD_256 - n));
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (WORD_512 - n));
    endfunction

    // Big-endian word j of a beat; byte k of the beat lives at [8k+7:8k].
    function automatic logic [63:0] be_word(input logic [511:0] d, input logic is512, input int j);
        logic [63:0] w;
        w = '0;
        if (is512)
            for (int b = 0; b < 8; b++) w[63-8*b -: 8] = d[64*j+8*b +: 8];
        else
            for (int b = 0; b < 4; b++) w[31-8*b -: 8] = d[32*j+8*b +: 8];
        return w;
    endfunction
endpackage

// File: rtl/sha2_sigma.sv
// sha2_sigma: small-sigma functions for SHA-256 (low 32 bits, upper zero) and SHA-512, selected by type.
module sha2_sigma
    import sha2_pkg::*;
(
    input  logic        sha_type_i,
    input  logic [63:0] x15_i,
    input  logic [63:0] x2_i,
    output logic [63:0] sigma0_o,
    output logic [63:0] sigma1_o
);
    logic [31:0] s0_32, s1_32;
    logic [63:0] s0_64, s1_64;

    assign s0_32 = rotr32(x15_i[31:0], 7) ^ rotr32(x15_i[31:0], 18) ^ (x15_i[31:0] >> 3);
    assign s1_32 = rotr32(x2_i[31:0], 17) ^ rotr32(x2_i[31:0], 19) ^ (x2_i[31:0] >> 10);
    assign s0_64 = rotr64(x15_i, 1) ^ rotr64(x15_i, 8) ^ (x15_i >> 7);
    assign s1_64 = rotr64(x2_i, 19) ^ rotr64(x2_i, 61) ^ (x2_i >> 6);

    assign sigma0_o = (sha_type_i == SHA_512) ? s0_64 : {32'd0, s0_32};
    assign sigma1_o = (sha_type_i == SHA_512) ? s1_64 : {32'd0, s1_32};
endmodule

// File: rtl/sha2_msg_scheduler.sv
// sha2_msg_scheduler: loads padded blocks from AXI-Stream and emits the expanded SHA-2 schedule W_t.
module sha2_msg_scheduler
    import sha2_pkg::*;
#(
    parameter int P_S_AXIS_DATA_WIDTH = 512,
    parameter int P_W_WIDTH = 64
) (
    input  logic                           axi_aclk,
    input  logic                           axi_reset,
    input  logic                           sha_type,
    input  logic [P_S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    output logic [P_W_WIDTH-1:0]           w_data,
    output logic                           w_valid,
    input  logic                           w_ready,
    output logic [6:0]                     w_round,
    output logic                           w_block_last,
    output logic                           w_msg_last
);
    state_e state_q, state_d;
    logic type_q, type_d;
    logic msg_last_q, msg_last_d;
    logic tready_q;
    logic valid_q, valid_d;
    logic block_last_q, block_last_d;
    logic [6:0] t_q, t_d, tn;
    logic [63:0] w_q, w_d;
    logic [63:0] wbuf_q [BUF_DEPTH];
    logic [3:0] i0, i2, i7, i15;
    logic [63:0] s0, s1, sum, w_exp, w_next;
    logic accept, hs;

    assign accept = s_axis_tvalid & tready_q;
    assign hs = valid_q & w_ready;
    assign tn = t_q + 7'd1;
    // Circular indices for W_{t+1}; all read slots were written at or before round t.
    assign i0 = tn[3:0];
    assign i2 = i0 - 4'd2;
    assign i7 = i0 - 4'd7;
    assign i15 = i0 - 4'd15;

    sha2_sigma u_sigma (
        .sha_type_i(type_q),
        .x15_i     (wbuf_q[i15]),
        .x2_i      (wbuf_q[i2]),
        .sigma0_o  (s0),
        .sigma1_o  (s1)
    );

    assign sum = s1 + wbuf_q[i7] + s0 + wbuf_q[i0];
    assign w_exp = (type_q == SHA_512) ? sum : {32'd0, sum[31:0]};
    assign w_next = (tn < 7'd16) ? wbuf_q[i0] : w_exp;

    always_comb begin
        state_d = state_q;
        type_d = type_q;
        msg_last_d = msg_last_q;
        t_d = t_q;
        w_d = w_q;
        valid_d = valid_q;
        block_last_d = block_last_q;
        case (state_q)
            IDLE: if (accept) begin
                type_d = sha_type;
                msg_last_d = s_axis_tlast;
                state_d = (sha_type == SHA_512) ? LOAD_HI : ROUND;
                if (sha_type == SHA_256) begin
                    t_d = '0;
                    w_d = be_word(s_axis_tdata, SHA_256, 0);
                    valid_d = 1'b1;
                    block_last_d = 1'b0;
                end
            end
            LOAD_HI: if (accept) begin
                msg_last_d = s_axis_tlast;
                state_d = ROUND;
                t_d = '0;
                w_d = wbuf_q[0];
                valid_d = 1'b1;
                block_last_d = 1'b0;
            end
            ROUND: if (hs) begin
                state_d = block_last_q ? IDLE : ROUND;
                valid_d = !block_last_q;
                t_d = block_last_q ? 7'd0 : tn;
                w_d = block_last_q ? w_q : w_next;
                block_last_d = !block_last_q && (tn == ((type_q == SHA_512) ? LAST_512 : LAST_256));
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q <= IDLE;
            type_q <= SHA_256;
            msg_last_q <= 1'b0;
            t_q <= '0;
            w_q <= '0;
            valid_q <= 1'b0;
            block_last_q <= 1'b0;
            tready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q <= type_d;
            msg_last_q <= msg_last_d;
            t_q <= t_d;
            w_q <= w_d;
            valid_q <= valid_d;
            block_last_q <= block_last_d;
            tready_q <= (state_d != ROUND);
        end
    end

    // Buffer contents are don't-care after reset, so they carry no reset.
    always_ff @(posedge axi_aclk) begin
        if (state_q == IDLE && accept) begin
            for (int j = 0; j < 16; j++)
                if (sha_type == SHA_256 || j < 8) wbuf_q[j] <= be_word(s_axis_tdata, sha_type, j);
        end else if (state_q == LOAD_HI && accept) begin
            for (int j = 0; j < 8; j++) wbuf_q[j+8] <= be_word(s_axis_tdata, SHA_512, j);
        end else if (state_q == ROUND && hs && !block_last_q && tn >= 7'd16) begin
            wbuf_q[i0] <= w_exp;
        end
    end

    assign s_axis_tready = tready_q;
    assign w_data = w_q;
    assign w_valid = valid_q;
    assign w_round = t_q;
    assign w_block_last = block_last_q;
    assign w_msg_last = msg_last_q;
endmodule

// File: tb/tb_sha2_msg_scheduler.sv
// tb_sha2_msg_scheduler: directed self-checking bench for the SHA-2 message scheduler.
module tb_sha2_msg_scheduler;
    logic axi_aclk = 1'b0;
    logic axi_reset = 1'b1;
    logic sha_type = 1'b0;
    logic [511:0] s_axis_tdata = '0;
    logic s_axis_tvalid = 1'b0;
    logic s_axis_tready;
    logic s_axis_tlast = 1'b0;
    logic [63:0] w_data;
    logic w_valid;
    logic w_ready = 1'b0;
    logic [6:0] w_round;
    logic w_block_last;
    logic w_msg_last;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [63:0] gw [80];
    logic [511:0] abc256, abc512_0, abc512_1;

    sha2_msg_scheduler dut (
        .axi_aclk     (axi_aclk),
        .axi_reset    (axi_reset),
        .sha_type     (sha_type),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .w_data       (w_data),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_round      (w_round),
        .w_block_last (w_block_last),
        .w_msg_last   (w_msg_last)
    );

    always #5 axi_aclk = ~axi_aclk;
    always @(posedge axi_aclk) cyc <= cyc + 1;

    function automatic logic [63:0] rr64(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic logic [31:0] rr32(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [63:0] gs0(input logic [63:0] x, input logic is512);
        if (is512) return rr64(x, 1) ^ rr64(x, 8) ^ (x >> 7);
        return {32'd0, rr32(x[31:0], 7) ^ rr32(x[31:0], 18) ^ (x[31:0] >> 3)};
    endfunction

    function automatic logic [63:0] gs1(input logic [63:0] x, input logic is512);
        if (is512) return rr64(x, 19) ^ rr64(x, 61) ^ (x >> 6);
        return {32'd0, rr32(x[31:0], 17) ^ rr32(x[31:0], 19) ^ (x[31:0] >> 10)};
    endfunction

    function automatic logic [511:0] pat(input logic [7:0] seed);
        logic [511:0] r;
        for (int k = 0; k < 64; k++) r[8*k +: 8] = seed + 8'(k * 7);
        return r;
    endfunction

    // Reference schedule: flat W[0..79] array, plain FIPS 180-4 recurrence.
    task automatic build_golden(input logic [511:0] b0, input logic [511:0] b1, input logic is512);
        logic [7:0] by [128];
        logic [63:0] s;
        for (int k = 0; k < 64; k++) begin
            by[k] = b0[8*k +: 8];
            by[64+k] = b1[8*k +: 8];
        end
        for (int j = 0; j < 16; j++) begin
            gw[j] = '0;
            for (int b = 0; b < (is512 ? 8 : 4); b++)
                gw[j] = {gw[j][55:0], by[(is512 ? 8 : 4) * j + b]};
        end
        for (int t = 16; t < 80; t++) begin
            s = gs1(gw[t-2], is512) + gw[t-7] + gs0(gw[t-15], is512) + gw[t-16];
            gw[t] = is512 ? s : {32'd0, s[31:0]};
        end
    endtask

    task automatic step();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic send_beat(input logic [511:0] d, input logic last, input logic typ, output bit ok);
        s_axis_tdata = d;
        s_axis_tlast = last;
        sha_type = typ;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 200 && s_axis_tready !== 1'b1; n++) step();
        ok = (s_axis_tready === 1'b1);
        step();
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
    endtask

    task automatic test_reset();
        axi_reset = 1'b1;
        w_ready = 1'b1;
        repeat (3) step();
        checks++;
        if ({s_axis_tready, w_valid, w_data, w_round, w_block_last, w_msg_last} !== '0) begin
            failures++;
            $display("FAIL reset_outputs tready=%0b valid=%0b data=%h round=%0d bl=%0b ml=%0b expected all 0",
                     s_axis_tready, w_valid, w_data, w_round, w_block_last, w_msg_last);
        end
        axi_reset = 1'b0;
        step();
        checks++;
        if (s_axis_tready !== 1'b1 || w_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release tready=%0b valid=%0b expected tready=1 valid=0", s_axis_tready, w_valid);
        end
    endtask

    task automatic test_sha256_abc();
        bit ok;
        logic [63:0] k;
        build_golden(abc256, '0, 1'b0);
        send_beat(abc256, 1'b1, 1'b0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL abc256_accept timed out waiting for tready"); end
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (w_valid !== 1'b1 || w_round !== 7'(t) || w_data !== gw[t]) begin
                failures++;
                $display("FAIL abc256_word t=%0d valid=%0b round=%0d data=%h expected data=%h", t, w_valid, w_round, w_data, gw[t]);
            end
            checks++;
            if (w_block_last !== (t == 63) || w_msg_last !== 1'b1) begin
                failures++;
                $display("FAIL abc256_flags t=%0d bl=%0b ml=%0b expected bl=%0b ml=1", t, w_block_last, w_msg_last, t == 63);
            end
            if (t == 0 || t == 15 || t == 16 || t == 17) begin
                k = (t == 0 || t == 16) ? 64'h61626380 : (t == 15) ? 64'h18 : 64'h000F0000;
                checks++;
                if (w_data !== k) begin
                    failures++;
                    $display("FAIL abc256_known t=%0d got=%h expected=%h", t, w_data, k);
                end
            end
            step();
        end
        checks++;
        if (w_valid !== 1'b0 || s_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL abc256_end valid=%0b tready=%0b expected valid=0 tready=1", w_valid, s_axis_tready);
        end
    endtask

    task automatic test_sha512_abc();
        bit ok;
        logic [63:0] k;
        build_golden(abc512_0, abc512_1, 1'b1);
        send_beat(abc512_0, 1'b1, 1'b1, ok);
        checks++;
        if (!ok || w_valid !== 1'b0 || s_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL abc512_beat0 ok=%0b valid=%0b tready=%0b expected ok=1 valid=0 tready=1", ok, w_valid, s_axis_tready);
        end
        send_beat(abc512_1, 1'b0, 1'b1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL abc512_beat1 timed out waiting for tready"); end
        for (int t = 0; t < 80; t++) begin
            checks++;
            if (w_valid !== 1'b1 || w_round !== 7'(t) || w_data !== gw[t]) begin
                failures++;
                $display("FAIL abc512_word t=%0d valid=%0b round=%0d data=%h expected data=%h", t, w_valid, w_round, w_data, gw[t]);
            end
            checks++;
            if (w_block_last !== (t == 79) || w_msg_last !== 1'b0) begin
                failures++;
                $display("FAIL abc512_flags t=%0d bl=%0b ml=%0b expected bl=%0b ml=0", t, w_block_last, w_msg_last, t == 79);
            end
            if (t == 0 || t == 15 || t == 16 || t == 17) begin
                k = (t == 0 || t == 16) ? 64'h6162638000000000 : (t == 15) ? 64'h18 : 64'h00030000000000C0;
                checks++;
                if (w_data !== k) begin
                    failures++;
                    $display("FAIL abc512_known t=%0d got=%h expected=%h", t, w_data, k);
                end
            end
            step();
        end
        checks++;
        if (w_valid !== 1'b0 || s_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL abc512_end valid=%0b tready=%0b expected valid=0 tready=1", w_valid, s_axis_tready);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [511:0] blk;
        blk = pat(8'h3C);
        build_golden(blk, '0, 1'b0);
        send_beat(blk, 1'b1, 1'b0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_accept timed out waiting for tready"); end
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (w_valid !== 1'b1 || w_round !== 7'(t) || w_data !== gw[t]) begin
                failures++;
                $display("FAIL bp_word t=%0d valid=%0b round=%0d data=%h expected data=%h", t, w_valid, w_round, w_data, gw[t]);
            end
            if (t == 20) begin
                w_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step();
                    checks++;
                    if (w_valid !== 1'b1 || w_round !== 7'd20 || w_data !== gw[20]) begin
                        failures++;
                        $display("FAIL bp_hold cycle=%0d valid=%0b round=%0d data=%h expected round=20 data=%h",
                                 s, w_valid, w_round, w_data, gw[20]);
                    end
                end
                w_ready = 1'b1;
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] b1d, b2d;
        int start;
        b1d = pat(8'h11);
        b2d = pat(8'hC7);
        build_golden(b1d, '0, 1'b0);
        s_axis_tdata = b1d;
        s_axis_tlast = 1'b0;
        sha_type = 1'b0;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 200 && s_axis_tready !== 1'b1; n++) step();
        checks++;
        if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL b2b_accept timed out waiting for tready"); end
        step();
        s_axis_tdata = b2d;
        s_axis_tlast = 1'b1;
        start = cyc;
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (w_valid !== 1'b1 || w_round !== 7'(t) || w_data !== gw[t] || w_msg_last !== 1'b0 || s_axis_tready !== 1'b0) begin
                failures++;
                $display("FAIL b2b_blk1 t=%0d valid=%0b round=%0d data=%h ml=%0b tready=%0b expected data=%h ml=0 tready=0",
                         t, w_valid, w_round, w_data, w_msg_last, s_axis_tready, gw[t]);
            end
            step();
        end
        checks++;
        if (w_valid !== 1'b0 || s_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_gap valid=%0b tready=%0b expected valid=0 tready=1", w_valid, s_axis_tready);
        end
        build_golden(b2d, '0, 1'b0);
        step();
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (w_valid !== 1'b1 || w_round !== 7'(t) || w_data !== gw[t] || w_msg_last !== 1'b1 || s_axis_tready !== 1'b0) begin
                failures++;
                $display("FAIL b2b_blk2 t=%0d valid=%0b round=%0d data=%h ml=%0b tready=%0b expected data=%h ml=1 tready=0",
                         t, w_valid, w_round, w_data, w_msg_last, s_axis_tready, gw[t]);
            end
            step();
        end
        checks++;
        if (cyc - start + 1 != 130) begin
            failures++;
            $display("FAIL b2b_cycles got=%0d expected=130", cyc - start + 1);
        end
    endtask

    task automatic test_reset_mid_block();
        bit ok;
        logic [511:0] blk;
        blk = pat(8'hA5);
        build_golden(blk, '0, 1'b0);
        send_beat(blk, 1'b1, 1'b0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rst_accept timed out waiting for tready"); end
        for (int t = 0; t < 30; t++) begin
            checks++;
            if (w_valid !== 1'b1 || w_round !== 7'(t) || w_data !== gw[t]) begin
                failures++;
                $display("FAIL rst_pre t=%0d valid=%0b round=%0d data=%h expected data=%h", t, w_valid, w_round, w_data, gw[t]);
            end
            step();
        end
        axi_reset = 1'b1;
        step();
        checks++;
        if (w_valid !== 1'b0 || s_axis_tready !== 1'b0 || w_round !== 7'd0) begin
            failures++;
            $display("FAIL rst_mid valid=%0b tready=%0b round=%0d expected all 0", w_valid, s_axis_tready, w_round);
        end
        axi_reset = 1'b0;
        step();
        checks++;
        if (w_valid !== 1'b0 || s_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL rst_after valid=%0b tready=%0b expected valid=0 tready=1", w_valid, s_axis_tready);
        end
        blk = pat(8'h5E);
        build_golden(blk, '0, 1'b0);
        send_beat(blk, 1'b0, 1'b0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rst_reaccept timed out waiting for tready"); end
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (w_valid !== 1'b1 || w_round !== 7'(t) || w_data !== gw[t] || w_block_last !== (t == 63)) begin
                failures++;
                $display("FAIL rst_post t=%0d valid=%0b round=%0d data=%h bl=%0b expected data=%h",
                         t, w_valid, w_round, w_data, w_block_last, gw[t]);
            end
            step();
        end
    endtask

    task automatic test_type_toggle();
        bit ok;
        build_golden(abc512_0, abc512_1, 1'b1);
        send_beat(abc512_0, 1'b0, 1'b1, ok);
        sha_type = 1'b0;
        send_beat(abc512_1, 1'b1, 1'b0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL tog_accept timed out waiting for tready"); end
        for (int t = 0; t < 80; t++) begin
            checks++;
            if (w_valid !== 1'b1 || w_round !== 7'(t) || w_data !== gw[t] || w_block_last !== (t == 79) || w_msg_last !== 1'b1) begin
                failures++;
                $display("FAIL tog_word t=%0d valid=%0b round=%0d data=%h bl=%0b ml=%0b expected data=%h",
                         t, w_valid, w_round, w_data, w_block_last, w_msg_last, gw[t]);
            end
            sha_type = ~sha_type;
            step();
        end
        checks++;
        if (w_valid !== 1'b0) begin
            failures++;
            $display("FAIL tog_end valid=%0b expected 0", w_valid);
        end
    endtask

    initial begin
        abc256 = '0;
        abc256[31:0] = 32'h80636261;
        abc256[511:504] = 8'h18;
        abc512_0 = '0;
        abc512_0[31:0] = 32'h80636261;
        abc512_1 = '0;
        abc512_1[511:504] = 8'h18;
        test_reset();
        test_sha256_abc();
        test_sha512_abc();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_block();
        test_type_toggle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
